// File: rtl/nasti_stream_pkg.sv
// Shared types and helpers for the NASTI-Stream width converters.
// The wide beat typedef uses default widths; parametrised users define their own matching struct.
package nasti_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 256;
    localparam int DEFAULT_ID_WIDTH   = 1;
    localparam int DEFAULT_DEST_WIDTH = 1;
    localparam int DEFAULT_USER_WIDTH = 1;

    // Value used to fill lanes that no upstream beat wrote.
    localparam logic LANE_PAD_BIT = 1'b0;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0]   data;
        logic [DEFAULT_DATA_WIDTH/8-1:0] strb;
        logic [DEFAULT_DATA_WIDTH/8-1:0] keep;
        logic                            last;
        logic [DEFAULT_ID_WIDTH-1:0]     id;
        logic [DEFAULT_DEST_WIDTH-1:0]   dest;
        logic [DEFAULT_USER_WIDTH-1:0]   user;
    } nasti_wide_beat_t;

    // Number of narrow beats per wide beat; 0 flags an unusable width pair.
    function automatic int packer_multiple(input int master_w, input int slave_w);
        if (master_w <= 0 || (slave_w % master_w) != 0)
            return 0;
        return slave_w / master_w;
    endfunction

endpackage

// File: rtl/nasti_stream_if.sv
// One NASTI-Stream channel; the master modport drives the beat, the slave modport drives ready.
interface nasti_stream_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic                    t_valid;
    logic                    t_ready;
    logic [DATA_WIDTH-1:0]   t_data;
    logic [DATA_WIDTH/8-1:0] t_strb;
    logic [DATA_WIDTH/8-1:0] t_keep;
    logic                    t_last;
    logic [ID_WIDTH-1:0]     t_id;
    logic [DEST_WIDTH-1:0]   t_dest;
    logic [USER_WIDTH-1:0]   t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        output t_ready
    );
endinterface

// File: rtl/nasti_stream_out_reg.sv
// Single-entry registered output stage: loads when empty or draining, holds under backpressure.
module nasti_stream_out_reg
    import nasti_stream_pkg::*;
#(
    parameter type beat_t = nasti_wide_beat_t
) (
    input  logic  aclk,
    input  logic  aresetn,
    input  logic  load_valid,
    output logic  load_ready,
    input  beat_t load_beat,
    output logic  out_valid,
    input  logic  out_ready,
    output beat_t out_beat
);

    assign load_ready = !out_valid || out_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (load_valid && load_ready) begin
            out_valid <= 1'b1;
            out_beat  <= load_beat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nasti_stream_packer.sv
// Narrow-to-wide NASTI-Stream packer: lane 0 first, early-last padding, split on id/dest change.
module nasti_stream_packer
    import nasti_stream_pkg::*;
#(
    parameter int ID_WIDTH          = 1,
    parameter int DEST_WIDTH        = 1,
    parameter int USER_WIDTH        = 1,
    parameter int MASTER_DATA_WIDTH = 64,
    parameter int SLAVE_DATA_WIDTH  = 256,
    parameter int SPLIT_ON_SIDEBAND = 1
) (
    input logic           aclk,
    input logic           aresetn,
    nasti_stream_if.slave  master,
    nasti_stream_if.master slave
);

    localparam int MULTIPLE = packer_multiple(MASTER_DATA_WIDTH, SLAVE_DATA_WIDTH);
    localparam int CNT_W    = (MULTIPLE > 2) ? $clog2(MULTIPLE) : 1;
    localparam int MW       = MASTER_DATA_WIDTH;
    localparam int SW       = SLAVE_DATA_WIDTH;
    localparam int MSTRB    = MW / 8;
    localparam int SSTRB    = SW / 8;

    generate
        if (MULTIPLE < 2 || (MW % 8) != 0) begin : g_bad_cfg
            $error("nasti_stream_packer: SLAVE_DATA_WIDTH must be an integer multiple >1 of byte-aligned MASTER_DATA_WIDTH");
        end
    endgenerate

    typedef struct packed {
        logic [SW-1:0]         data;
        logic [SSTRB-1:0]      strb;
        logic [SSTRB-1:0]      keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    logic [CNT_W-1:0]      cnt;
    logic [SW-1:0]         asm_data;
    logic [SSTRB-1:0]      asm_strb;
    logic [SSTRB-1:0]      asm_keep;
    logic [ID_WIDTH-1:0]   held_id;
    logic [DEST_WIDTH-1:0] held_dest;
    logic [USER_WIDTH-1:0] held_user;

    logic                  out_free;
    logic                  split;
    logic                  closing;
    logic                  accept;
    logic                  load_valid;
    logic                  out_valid;
    beat_t                 load_beat;
    beat_t                 out_beat;
    logic [SW-1:0]         merged_data;
    logic [SSTRB-1:0]      merged_strb;
    logic [SSTRB-1:0]      merged_keep;

    assign split = (SPLIT_ON_SIDEBAND != 0) && (cnt != '0) && master.t_valid &&
                   ((master.t_id != held_id) || (master.t_dest != held_dest));
    assign closing = master.t_last || (cnt == CNT_W'(MULTIPLE - 1));

    // A closing beat cannot share the edge with a split flush, so it waits one cycle.
    assign master.t_ready = aresetn && out_free && !(split && master.t_last);
    assign accept         = master.t_valid && master.t_ready;
    assign load_valid     = split ? out_free : (accept && closing);

    // Lanes at or above cnt are always zero in the assembly registers, so padding is implicit.
    always_comb begin
        merged_data = asm_data;
        merged_strb = asm_strb;
        merged_keep = asm_keep;
        for (int i = 0; i < MULTIPLE; i++) begin
            if (cnt == CNT_W'(i)) begin
                merged_data[i*MW +: MW]       = master.t_data;
                merged_strb[i*MSTRB +: MSTRB] = master.t_strb;
                merged_keep[i*MSTRB +: MSTRB] = master.t_keep;
            end
        end
    end

    always_comb begin
        load_beat = '0;
        if (split) begin
            load_beat.data = asm_data;
            load_beat.strb = asm_strb;
            load_beat.keep = asm_keep;
            load_beat.last = 1'b0;
            load_beat.id   = held_id;
            load_beat.dest = held_dest;
            load_beat.user = held_user;
        end else begin
            load_beat.data = merged_data;
            load_beat.strb = merged_strb;
            load_beat.keep = merged_keep;
            load_beat.last = master.t_last;
            load_beat.id   = (cnt == '0) ? master.t_id   : held_id;
            load_beat.dest = (cnt == '0) ? master.t_dest : held_dest;
            load_beat.user = (cnt == '0) ? master.t_user : held_user;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt       <= '0;
            asm_data  <= '0;
            asm_strb  <= '0;
            asm_keep  <= '0;
            held_id   <= '0;
            held_dest <= '0;
            held_user <= '0;
        end else if (split && out_free) begin
            asm_data <= {SW{LANE_PAD_BIT}};
            asm_strb <= {SSTRB{LANE_PAD_BIT}};
            asm_keep <= {SSTRB{LANE_PAD_BIT}};
            cnt      <= '0;
            if (accept) begin
                asm_data[MW-1:0]    <= master.t_data;
                asm_strb[MSTRB-1:0] <= master.t_strb;
                asm_keep[MSTRB-1:0] <= master.t_keep;
                cnt                 <= CNT_W'(1);
                held_id             <= master.t_id;
                held_dest           <= master.t_dest;
                held_user           <= master.t_user;
            end
        end else if (accept) begin
            if (closing) begin
                asm_data <= {SW{LANE_PAD_BIT}};
                asm_strb <= {SSTRB{LANE_PAD_BIT}};
                asm_keep <= {SSTRB{LANE_PAD_BIT}};
                cnt      <= '0;
            end else begin
                asm_data <= merged_data;
                asm_strb <= merged_strb;
                asm_keep <= merged_keep;
                cnt      <= cnt + CNT_W'(1);
                if (cnt == '0) begin
                    held_id   <= master.t_id;
                    held_dest <= master.t_dest;
                    held_user <= master.t_user;
                end
            end
        end
    end

    nasti_stream_out_reg #(
        .beat_t (beat_t)
    ) u_out_reg (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load_valid (load_valid),
        .load_ready (out_free),
        .load_beat  (load_beat),
        .out_valid  (out_valid),
        .out_ready  (slave.t_ready),
        .out_beat   (out_beat)
    );

    assign slave.t_valid = out_valid;
    assign slave.t_data  = out_beat.data;
    assign slave.t_strb  = out_beat.strb;
    assign slave.t_keep  = out_beat.keep;
    assign slave.t_last  = out_beat.last;
    assign slave.t_id    = out_beat.id;
    assign slave.t_dest  = out_beat.dest;
    assign slave.t_user  = out_beat.user;

endmodule

// File: tb/tb_nasti_stream_packer.sv
// Scoreboard bench for nasti_stream_packer (64 -> 256 bits): words are predicted from the
// issued beat order alone and checked by an independent monitor on the downstream side.
module tb_nasti_stream_packer;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    nasti_stream_if #(.DATA_WIDTH(64),  .ID_WIDTH(2), .DEST_WIDTH(1), .USER_WIDTH(1)) mst_if ();
    nasti_stream_if #(.DATA_WIDTH(256), .ID_WIDTH(2), .DEST_WIDTH(1), .USER_WIDTH(1)) slv_if ();

    nasti_stream_packer #(
        .ID_WIDTH          (2),
        .DEST_WIDTH        (1),
        .USER_WIDTH        (1),
        .MASTER_DATA_WIDTH (64),
        .SLAVE_DATA_WIDTH  (256),
        .SPLIT_ON_SIDEBAND (1)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .master  (mst_if),
        .slave   (slv_if)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  keep;
        logic        last;
        logic [1:0]  id;
        logic        dest;
        logic        user;
    } nbeat_t;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [31:0]  keep;
        logic         last;
        logic [1:0]   id;
        logic         dest;
        logic         user;
    } wbeat_t;

    nbeat_t cur[$];
    wbeat_t expq[$];
    int     checks = 0;
    int     errors = 0;
    logic   ready_cmd = 1'b0;
    logic   rand_ready = 1'b0;

    // Reference: a word is whatever beats were issued since the last close, lane 0 first.
    function automatic void closeWord(input logic last);
        wbeat_t w;
        w.data = '0;
        w.strb = '0;
        w.keep = '0;
        for (int i = 0; i < cur.size(); i++) begin
            w.data[i*64 +: 64] = cur[i].data;
            w.strb[i*8 +: 8]   = cur[i].strb;
            w.keep[i*8 +: 8]   = cur[i].keep;
        end
        w.last = last;
        w.id   = cur[0].id;
        w.dest = cur[0].dest;
        w.user = cur[0].user;
        expq.push_back(w);
        cur.delete();
    endfunction

    function automatic void modelBeat(input nbeat_t b);
        if (cur.size() > 0 && (b.id != cur[0].id || b.dest != cur[0].dest))
            closeWord(1'b0);
        cur.push_back(b);
        if (b.last || cur.size() == 4)
            closeWord(b.last);
    endfunction

    function automatic void checkEq(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endfunction

    function automatic nbeat_t mkBeat(input logic [63:0] d, input logic [7:0] s, input logic l, input logic [1:0] id);
        nbeat_t b;
        b.data = d;
        b.strb = s;
        b.keep = s;
        b.last = l;
        b.id   = id;
        b.dest = 1'b0;
        b.user = id[0];
        return b;
    endfunction

    function automatic nbeat_t randBeat(input logic l, input logic [1:0] id, input logic dest);
        nbeat_t b;
        b.data = {$urandom, $urandom};
        b.strb = 8'($urandom);
        b.keep = 8'($urandom);
        b.last = l;
        b.id   = id;
        b.dest = dest;
        b.user = 1'($urandom);
        return b;
    endfunction

    task automatic applyStimulus(input nbeat_t b, output int stalls);
        bit done;
        modelBeat(b);
        mst_if.t_valid = 1'b1;
        mst_if.t_data  = b.data;
        mst_if.t_strb  = b.strb;
        mst_if.t_keep  = b.keep;
        mst_if.t_last  = b.last;
        mst_if.t_id    = b.id;
        mst_if.t_dest  = b.dest;
        mst_if.t_user  = b.user;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge aclk);
            if (mst_if.t_ready) done = 1'b1;
            else stalls++;
            @(posedge aclk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout got=no_ready expected=ready_within_1000_cycles");
        end
        mst_if.t_valid = 1'b0;
    endtask

    task automatic checkOutput();
        wbeat_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word got=%h expected=no_word", slv_if.t_data);
        end else begin
            e = expq.pop_front();
            checkEq("word_data", slv_if.t_data, e.data);
            checkEq("word_strb_keep", {192'd0, slv_if.t_strb, slv_if.t_keep}, {192'd0, e.strb, e.keep});
            checkEq("word_sideband", {251'd0, slv_if.t_last, slv_if.t_id, slv_if.t_dest, slv_if.t_user},
                    {251'd0, e.last, e.id, e.dest, e.user});
        end
    endtask

    // Monitor: a word is consumed when valid and ready are both high at the coming edge.
    always @(negedge aclk) begin
        if (aresetn && slv_if.t_valid && slv_if.t_ready)
            checkOutput();
    end

    initial begin
        slv_if.t_ready = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            slv_if.t_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int st;
        int total;
        nbeat_t b;
        mst_if.t_valid = 1'b0;
        mst_if.t_data  = '0;
        mst_if.t_strb  = '0;
        mst_if.t_keep  = '0;
        mst_if.t_last  = 1'b0;
        mst_if.t_id    = '0;
        mst_if.t_dest  = 1'b0;
        mst_if.t_user  = 1'b0;

        // Reset values
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkEq("reset_slave_valid", {255'd0, slv_if.t_valid}, 256'd0);
        checkEq("reset_slave_data", slv_if.t_data, 256'd0);
        checkEq("reset_master_ready", {255'd0, mst_if.t_ready}, 256'd0);
        ready_cmd = 1'b1;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        $display("[TB] full word");
        total = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkBeat(64'hD0D0_0000_0000_0000 + 64'(i), 8'hFF, i == 3, 2'd0), st);
            total += st;
        end
        checkEq("full_latency_valid", {255'd0, slv_if.t_valid}, 256'd1);
        checkEq("full_no_stall", 256'(total), 256'd0);

        $display("[TB] early last");
        applyStimulus(mkBeat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0, 2'd0), st);
        applyStimulus(mkBeat(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b1, 2'd0), st);
        checkEq("early_strb", {224'd0, slv_if.t_strb}, {224'd0, 32'h0000FFFF});

        $display("[TB] backpressure");
        repeat (2) @(posedge aclk);
        #1 ready_cmd = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++)
            applyStimulus(mkBeat(64'h1000 + 64'(i), 8'hFF, i == 3, 2'd1), st);
        checkEq("bp_ready_low", {255'd0, mst_if.t_ready}, 256'd0);
        checkEq("bp_word0_present", slv_if.t_data, expq[0].data);
        repeat (5) @(posedge aclk);
        #1;
        checkEq("bp_word0_held", slv_if.t_data, expq[0].data);
        checkEq("bp_valid_held", {255'd0, slv_if.t_valid}, 256'd1);
        fork
            for (int i = 0; i < 4; i++)
                applyStimulus(mkBeat(64'h2000 + 64'(i), 8'hFF, i == 3, 2'd1), st);
            begin
                repeat (3) @(posedge aclk);
                #1 ready_cmd = 1'b1;
            end
        join

        $display("[TB] sustained throughput");
        total = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(randBeat((i % 4) == 3, 2'd2, 1'b1), st);
            total += st;
        end
        checkEq("throughput_stalls", 256'(total), 256'd0);

        $display("[TB] sideband split");
        applyStimulus(mkBeat(64'h0000_0000_0000_00A1, 8'hFF, 1'b0, 2'd1), st);
        applyStimulus(mkBeat(64'h0000_0000_0000_00A2, 8'hFF, 1'b0, 2'd1), st);
        applyStimulus(mkBeat(64'h0000_0000_0000_00A3, 8'hFF, 1'b0, 2'd2), st);
        checkEq("split_nonlast_stall", 256'(st), 256'd0);
        applyStimulus(mkBeat(64'h0000_0000_0000_00A4, 8'h0F, 1'b1, 2'd2), st);
        applyStimulus(mkBeat(64'h0000_0000_0000_00B1, 8'hFF, 1'b0, 2'd1), st);
        applyStimulus(mkBeat(64'h0000_0000_0000_00B2, 8'hFF, 1'b0, 2'd1), st);
        applyStimulus(mkBeat(64'h0000_0000_0000_00B3, 8'hFF, 1'b1, 2'd2), st);
        checkEq("split_last_stall", 256'(st), 256'd1);

        $display("[TB] reset mid-word");
        repeat (3) @(posedge aclk);
        #1;
        applyStimulus(mkBeat(64'hDEAD_0000_0000_0001, 8'hFF, 1'b0, 2'd0), st);
        applyStimulus(mkBeat(64'hDEAD_0000_0000_0002, 8'hFF, 1'b0, 2'd0), st);
        aresetn = 1'b0;
        cur.delete();
        #1;
        checkEq("midreset_valid", {255'd0, slv_if.t_valid}, 256'd0);
        checkEq("midreset_data", slv_if.t_data, 256'd0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(mkBeat(64'hC1EA_0000_0000_0000 + 64'(i), 8'hFF, i == 3, 2'd3), st);

        $display("[TB] random mix");
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            b = randBeat((i == 299) || ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 1)), 1'($urandom));
            applyStimulus(b, st);
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        for (int c = 0; c < 500 && expq.size() > 0; c++)
            @(posedge aclk);
        repeat (2) @(posedge aclk);
        checkEq("drain_empty", 256'(expq.size()), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nasti_stream_packer.md
Name: nasti_stream_packer

Overview:
Parametrised next-generation NASTI-Stream width up-converter. It packs MULTIPLE narrow beats from the upstream side into one wide beat on the downstream side, lane 0 first. Unlike the plain widener it has these features:
- Full-throughput double buffering.
- Early-t_last termination with zero-padded strb/keep.
- Automatic word split when id/dest changes mid-word.

It sits between a narrow stream producer (e.g. a 64-bit DMA) and a wide stream consumer or crossbar.

Parameters:
ID_WIDTH, 1, t_id width
DEST_WIDTH, 1, t_dest width
USER_WIDTH, 1, t_user width
MASTER_DATA_WIDTH, 64, upstream (input) data width, multiple of 8
SLAVE_DATA_WIDTH, 256, downstream (output) data width; MULTIPLE = SLAVE/MASTER, integer and >1, else elaboration $error
SPLIT_ON_SIDEBAND, 1, 1 = close the partial word when incoming id/dest differ from the held word; 0 = ignore the difference (first-beat sideband wins)

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
master_t_valid  in  1  upstream beat valid
master_t_ready  out  1  upstream beat accepted
master_t_data  in  MASTER_DATA_WIDTH  upstream data
master_t_strb  in  MASTER_DATA_WIDTH/8  upstream strobe
master_t_keep  in  MASTER_DATA_WIDTH/8  upstream keep
master_t_last  in  1  end of packet
master_t_id  in  ID_WIDTH  stream id
master_t_dest  in  DEST_WIDTH  destination
master_t_user  in  USER_WIDTH  user sideband
slave_t_valid  out  1  wide beat valid
slave_t_ready  in  1  downstream ready
slave_t_data  out  SLAVE_DATA_WIDTH  packed data
slave_t_strb  out  SLAVE_DATA_WIDTH/8  packed strobe
slave_t_keep  out  SLAVE_DATA_WIDTH/8  packed keep
slave_t_last  out  1  word ends a packet
slave_t_id  out  ID_WIDTH  id of word
slave_t_dest  out  DEST_WIDTH  dest of word
slave_t_user  out  USER_WIDTH  user of word

Behaviour:
- Two stages:
  - Assembly stage: lane regs, cnt of width $clog2(MULTIPLE), held id/dest/user. It holds only incomplete words.
  - Output register: slave_* signals, fully registered.
- Reset:
  - cnt=0; slave_t_valid=0; all slave_* data/sideband outputs=0.
  - master_t_ready=0 while aresetn low.
  - Reset mid-word silently discards the partial word and any pending output.
- master_t_ready = !slave_t_valid || slave_t_ready. The only exception is the split-stall case below.
- Accepted beat at cnt=k writes lane k. Sideband is captured from the lane-0 beat.
- A beat is "closing" if k==MULTIPLE-1 or master_t_last=1.
- Closing beat: the assembled word plus this beat goes directly into the output register on the same edge. Lanes >k get data=0, strb=0, keep=0. slave_t_last=master_t_last. cnt returns to 0.
- Latency: closing beat accepted at edge N gives slave_t_valid=1 after edge N.
- Throughput: one input beat per cycle sustained with slave_t_ready=1 (1 output per MULTIPLE cycles).
- Output holds stable while slave_t_valid && !slave_t_ready. slave_t_valid drops after handshake unless a new word loads on the same edge.
- Split (SPLIT_ON_SIDEBAND=1, cnt>0, master_t_valid, incoming id or dest differs from held):
  - The partial word moves to the output register with slave_t_last=0 and padded lanes zero. This requires the output register free (same ready rule).
  - If the incoming beat is non-closing, it is accepted into lane 0 on the same edge (cnt=1).
  - If it is closing (t_last), master_t_ready=0 that cycle; the beat is accepted on a later cycle as a lane-0 closing beat.
- A non-closing beat never needs the output register. Ready still follows the common rule so it depends only on output state (plus the split case).
- master_t_ready may depend on master_t_valid/id/dest only in the split case; it never depends on slave_t_ready combinationally to upstream when slave_t_valid=0.

Decomposition:
- nasti_stream_pkg: add function packer_multiple(master_w, slave_w), the lane-pad constant, and a typedef for the wide beat struct (data/strb/keep/last/id/dest/user).
- One sub-module: nasti_stream_out_reg. It is the single-entry registered output stage with valid/ready and hold semantics, and is reusable by the narrower.

Test Plan:
All scenarios use MASTER=64, SLAVE=256 (MULTIPLE=4) unless stated.
- Full word: 4 beats D0..D3, strb=FF, last on D3, slave_t_ready=1 → one beat {D3,D2,D1,D0}, strb=32'hFFFFFFFF, last=1, valid one cycle after D3; master_t_ready stays 1.
- Early last: 2 beats A,B, last on B → data={0,0,B,A}, strb=keep=32'h0000FFFF, last=1.
- Backpressure: 8 beats with slave_t_ready=0 → master_t_ready falls after beat 4 is accepted. Output holds word0 unchanged. Raising ready gives word0 then word1 back-to-back, with no loss or duplication.
- Sustained throughput: 400 random beats, slave_t_ready=1 → zero upstream stall cycles; scoreboard matches all 100 words.
- Sideband split: id=1 beats X,Y then id=2 beat Z (not last) → word {0,0,Y,X} id=1 last=0 is emitted; Z starts new word at lane 0. With Z last=1 instead → one stall cycle, then word {0,0,0,Z} id=2 last=1.
- Reset mid-word: 2 beats in, aresetn pulsed low → slave_t_valid=0, outputs=0. The next 4 beats form a clean word with no stale lanes.
